shift_unit: RTL and testbench

Parametrised iterative shift/rotate unit for the datapath, successor to the fixed 8-bit shifter. Supports logical, arithmetic, rotate and rotate-through-carry operations with a multi-bit shift amount, one bit position per clock. Operands arrive and results leave over valid/ready handshakes, so the controller can stall either side. Result flags (carry-out, zero) feed the status register.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_step.sv | 54 +++++
 rtl/shift_unit.sv | 134 +++++++++++++
 tb/tb_shift_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the iterative shift/rotate unit: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ROR  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_SHL  = 3'b100,
    OP_ASR  = 3'b101,
    OP_RCR  = 3'b110,
    OP_RCL  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate of {carry, value}; purely combinational.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             carry,
  input  logic [WIDTH-1:0] value,
  input  op_e              op,
  output logic             carry_next,
  output logic [WIDTH-1:0] value_next
);

  // single-bit step; the carry slot always receives the bit that leaves the word
  always_comb begin
    value_next = value;
    carry_next = carry;
    case (op)
      OP_ROR: begin
        value_next = {value[0], value[WIDTH-1:1]};
        carry_next = value[0];
      end
      OP_SHR: begin
        value_next = {1'b0, value[WIDTH-1:1]};
        carry_next = value[0];
      end
      OP_ROL: begin
        value_next = {value[WIDTH-2:0], value[WIDTH-1]};
        carry_next = value[WIDTH-1];
      end
      OP_SHL: begin
        value_next = {value[WIDTH-2:0], 1'b0};
        carry_next = value[WIDTH-1];
      end
      OP_ASR: begin
        value_next = {value[WIDTH-1], value[WIDTH-1:1]};
        carry_next = value[0];
      end
      OP_RCR: begin
        value_next = {carry, value[WIDTH-1:1]};
        carry_next = value[0];
      end
      OP_RCL: begin
        value_next = {value[WIDTH-2:0], carry};
        carry_next = value[WIDTH-1];
      end
      default: begin
        value_next = value;
        carry_next = carry;
      end
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Iterative shift/rotate unit: accepts an operand bundle, shifts one position per clock,
// then presents y/cout/zero until the consumer takes them.
module shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       op,
  input  logic [AMTW-1:0]  amt,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             busy
);

  localparam logic [AMTW-1:0] WIDTH_A = AMTW'(WIDTH);
  localparam logic [AMTW-1:0] ONE_A   = AMTW'(1);
  localparam logic [AMTW-1:0] ZERO_A  = {AMTW{1'b0}};

  state_e           state_r;
  op_e              op_r;
  logic [WIDTH-1:0] val_r;
  logic             car_r;
  logic [AMTW-1:0]  cnt_r;
  logic [AMTW-1:0]  cnt_s;
  logic [WIDTH-1:0] step_val_s;
  logic             step_car_s;
  logic [WIDTH-1:0] y_r;
  logic             cout_r;
  logic             zero_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             busy_r;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .carry      (car_r),
    .value      (val_r),
    .op         (op_r),
    .carry_next (step_car_s),
    .value_next (step_val_s)
  );

  // effective step count: PASS never shifts, larger amounts saturate at WIDTH
  always_comb begin
    if (op_e'(op) == OP_PASS) begin
      cnt_s = ZERO_A;
    end else if (amt > WIDTH_A) begin
      cnt_s = WIDTH_A;
    end else begin
      cnt_s = amt;
    end
  end

  // control FSM with working registers and registered result/handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      op_r        <= OP_PASS;
      val_r       <= {WIDTH{1'b0}};
      car_r       <= 1'b0;
      cnt_r       <= ZERO_A;
      y_r         <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            val_r      <= a;
            car_r      <= cin;
            op_r       <= op_e'(op);
            cnt_r      <= cnt_s;
            state_r    <= (cnt_s == ZERO_A) ? S_DONE : S_SHIFT;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        S_SHIFT: begin
          val_r <= step_val_s;
          car_r <= step_car_s;
          cnt_r <= cnt_r - ONE_A;
          // final step publishes its own output directly so no extra cycle is spent
          if (cnt_r == ONE_A) begin
            state_r     <= S_DONE;
            y_r         <= step_val_s;
            cout_r      <= step_car_s;
            zero_r      <= (step_val_s == {WIDTH{1'b0}});
            out_valid_r <= 1'b1;
          end
        end
        S_DONE: begin
          // zero-count operations arrive here without a result yet; publish the latched operand
          if (!out_valid_r) begin
            y_r         <= val_r;
            cout_r      <= car_r;
            zero_r      <= (val_r == {WIDTH{1'b0}});
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign y         = y_r;
  assign cout      = cout_r;
  assign zero      = zero_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit (WIDTH=8) against a whole-word arithmetic reference model.
module tb_shift_unit;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [2:0] op;
  logic [3:0] amt;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       cout;
  logic       zero;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  shift_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .op        (op),
    .amt       (amt),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-count shifts/rotates computed in one go on wide integers.
  function automatic void model(input logic [2:0] o, input logic [7:0] av, input logic [3:0] am,
                                input logic c, output logic [7:0] ey, output logic ec, output int n);
    int unsigned x;
    int unsigned v9;
    int unsigned r;
    int          sx;
    x  = 32'(av);
    v9 = 32'({c, av});
    sx = int'($signed(av));
    if (o == 3'd0) n = 0;
    else if (am > 4'd8) n = 8;
    else n = int'(am);
    ey = av;
    ec = c;
    if (n != 0) begin
      case (o)
        3'd1: begin ey = 8'((x >> n) | (x << (8 - n))); ec = 1'((x >> (n - 1)) & 32'd1); end
        3'd2: begin ey = 8'(x >> n);                    ec = 1'((x >> (n - 1)) & 32'd1); end
        3'd3: begin ey = 8'((x << n) | (x >> (8 - n))); ec = 1'((x >> (8 - n)) & 32'd1); end
        3'd4: begin ey = 8'(x << n);                    ec = 1'((x >> (8 - n)) & 32'd1); end
        3'd5: begin ey = 8'(sx >>> n);                  ec = 1'((x >> (n - 1)) & 32'd1); end
        3'd6: begin
          r  = ((v9 >> n) | (v9 << (9 - n))) & 32'h1FF;
          ey = 8'(r);
          ec = 1'(r >> 8);
        end
        3'd7: begin
          r  = ((v9 << n) | (v9 >> (9 - n))) & 32'h1FF;
          ey = 8'(r);
          ec = 1'(r >> 8);
        end
        default: begin ey = av; ec = c; end
      endcase
    end
  endfunction

  // One complete transaction; hold>0 keeps out_ready low that many cycles while pulsing in_valid.
  task automatic run_op(input logic [2:0] o, input logic [7:0] av, input logic [3:0] am,
                        input logic c, input int hold, input string nm);
    logic [7:0] ey;
    logic       ec;
    logic       ez;
    int         n;
    int         elat;
    int         lat;
    int         w;
    logic       busy_ok;
    logic       stable_ok;
    model(o, av, am, c, ey, ec, n);
    ez   = (ey == 8'h00);
    elat = (n < 1) ? 1 : n;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept got=%b want=1", nm, in_ready);
    end
    in_valid = 1'b1; a = av; op = o; amt = am; cin = c;
    tick();
    // scramble inputs after accept; they must not affect the result
    in_valid = 1'b0;
    a   = 8'($urandom);
    op  = 3'($urandom);
    amt = 4'($urandom);
    cin = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
      tick();
      lat++;
    end
    checks++;
    if (lat != elat) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", nm, lat, elat);
    end
    checks++;
    if (busy_ok !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_while_working got=%b/%b want=1/1", nm, busy_ok, busy);
    end
    checks++;
    if (y !== ey) begin
      failures++;
      $display("FAIL %s y op=%0d a=%h amt=%0d cin=%b got=%h want=%h", nm, o, av, am, c, y, ey);
    end
    checks++;
    if (cout !== ec) begin
      failures++;
      $display("FAIL %s cout op=%0d a=%h amt=%0d cin=%b got=%b want=%b", nm, o, av, am, c, cout, ec);
    end
    checks++;
    if (zero !== ez) begin
      failures++;
      $display("FAIL %s zero got=%b want=%b", nm, zero, ez);
    end
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = ((i % 2) == 0);
      a = 8'($urandom);
      tick();
      if (out_valid !== 1'b1 || y !== ey || cout !== ec || zero !== ez || in_ready !== 1'b0 || busy !== 1'b1)
        stable_ok = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) begin
      checks++;
      if (stable_ok !== 1'b1) begin
        failures++;
        $display("FAIL %s backpressure_hold got_stable=%b want=1 (y=%h want %h)", nm, stable_ok, y, ey);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s handshake got v/r/b=%b%b%b want=010", nm, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; op = 3'd0; amt = 4'd0; cin = 1'b0;
    tick();
    tick();
    checks++;
    if (y !== 8'h00 || cout !== 1'b0 || zero !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_values got y=%h c=%b z=%b v=%b b=%b r=%b want 00 0 0 0 0 1",
               y, cout, zero, out_valid, busy, in_ready);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op(3'd1, 8'h81, 4'd1,  1'b0, 0, "ror_81_1");
    run_op(3'd4, 8'h81, 4'd3,  1'b0, 0, "shl_81_3");
    run_op(3'd5, 8'h90, 4'd2,  1'b0, 0, "asr_90_2");
    run_op(3'd0, 8'h5A, 4'd7,  1'b1, 0, "pass_5a");
    run_op(3'd7, 8'h80, 4'd1,  1'b0, 0, "rcl_80_1");
    run_op(3'd6, 8'h01, 4'd1,  1'b1, 0, "rcr_01_1");
    run_op(3'd2, 8'hFF, 4'd12, 1'b0, 0, "shr_clamp_12");
    run_op(3'd3, 8'hC3, 4'd0,  1'b1, 0, "rol_amt0");
    run_op(3'd6, 8'hA5, 4'd8,  1'b0, 0, "rcr_full_8");
    run_op(3'd7, 8'h3C, 4'd15, 1'b1, 0, "rcl_clamp_15");
  endtask

  task automatic test_backpressure();
    run_op(3'd4, 8'h81, 4'd3, 1'b0, 5, "bp_shl");
    run_op(3'd0, 8'h00, 4'd2, 1'b1, 5, "bp_pass_zero");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom), 1'($urandom),
             $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ey;
    logic       ec;
    int         n;
    int         results;
    logic       vals_ok;
    logic       hs_out;
    model(3'd3, 8'h96, 4'd3, 1'b0, ey, ec, n);
    results = 0;
    vals_ok = 1'b1;
    in_valid = 1'b1; a = 8'h96; op = 3'd3; amt = 4'd3; cin = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      hs_out = out_valid & out_ready;
      if (hs_out === 1'b1) begin
        results++;
        if (y !== ey || cout !== ec) vals_ok = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    checks++;
    if (results != 4) begin
      failures++;
      $display("FAIL b2b_throughput got=%0d results want=4", results);
    end
    checks++;
    if (vals_ok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_values got_ok=%b want=1 (want y=%h c=%b)", vals_ok, ey, ec);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic seen_valid;
    in_valid = 1'b1; a = 8'hA5; op = 3'd2; amt = 4'd8; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midshift_precondition got busy=%b v=%b want 1 0", busy, out_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (y !== 8'h00 || cout !== 1'b0 || zero !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midshift_reset_async got y=%h c=%b z=%b v=%b b=%b r=%b want 00 0 0 0 0 1",
               y, cout, zero, out_valid, busy, in_ready);
    end
    tick();
    reset = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen_valid = 1'b1;
      tick();
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("FAIL midshift_discarded got_activity=%b want=0", seen_valid);
    end
    run_op(3'd5, 8'h81, 4'd4, 1'b0, 0, "after_reset_asr");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
